// File: rtl/fft_reorder_buf.sv
// Natural-order output stage for the 32-point SDF FFT: ping-pong buffer, bit-reversed writes, linear reads.
// Optional FFT_REORDER_FLUSH_EN adds a synchronous flush input that discards the frame in progress.
module fft_reorder_buf #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_r,
    input  logic [W-1:0]     in_i,
    output logic             out_valid,
    output logic [W-1:0]     out_r,
    output logic [W-1:0]     out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last
`ifdef FFT_REORDER_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    logic                 flush_w;
    logic                 wr_en;
    logic                 frame_done;
    logic [LOG2N-1:0]     wr_cnt_q, wr_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0]     wr_addr_rev;
    logic [2*W-1:0]       mem_q [2*N];
    logic [2*W-1:0]       rd_word;

    rd_state_t            state_q;
    logic [LOG2N-1:0]     rd_cnt_q;
    logic                 start_pend_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [W-1:0]         out_r_q;
    logic [W-1:0]         out_i_q;
    logic [LOG2N-1:0]     out_idx_q;

`ifdef FFT_REORDER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Bit-reversing the write address makes the linear read come out in natural order.
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign wr_addr_rev[gi] = wr_cnt_q[LOG2N-1-gi];
        end
    endgenerate

    assign wr_en      = in_valid & ~flush_w;
    assign frame_done = wr_en && (wr_cnt_q == LAST_IDX);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (flush_w) begin
            wr_cnt_d = '0;
        end else if (in_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_addr_rev}] <= {in_r, in_i};
        end
    end

    // The reader always uses the bank the writer is not filling.
    assign rd_word = mem_q[{~wr_bank_q, rd_cnt_q}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= R_IDLE;
            rd_cnt_q     <= '0;
            start_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
            out_idx_q    <= '0;
        end else if (flush_w) begin
            state_q      <= R_IDLE;
            rd_cnt_q     <= '0;
            start_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    if (frame_done) begin
                        state_q      <= R_READ;
                        rd_cnt_q     <= '0;
                        start_pend_q <= 1'b0;
                    end
                end
                R_READ: begin
                    out_r_q     <= rd_word[2*W-1:W];
                    out_i_q     <= rd_word[W-1:0];
                    out_idx_q   <= rd_cnt_q;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (rd_cnt_q == LAST_IDX);
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_q     <= '0;
                        start_pend_q <= 1'b0;
                        if (!(frame_done || start_pend_q)) begin
                            state_q <= R_IDLE;
                        end
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (frame_done) begin
                            start_pend_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: frames driven in bit-reversed order, natural order expected.
`timescale 1ns/1ps
module tb_fft_reorder_buf;

    localparam int N = 32;
    localparam int W = 19;

    typedef struct packed {
        logic [4:0]          idx;
        logic signed [W-1:0] r;
        logic signed [W-1:0] i;
        logic                last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_r = '0;
    logic signed [W-1:0] in_i = '0;
    logic                out_valid;
    logic signed [W-1:0] out_r;
    logic signed [W-1:0] out_i;
    logic [4:0]          out_idx;
    logic                out_last;
`ifdef FFT_REORDER_FLUSH_EN
    logic                flush = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t                sb_q[$];
    int                  first_q[$];
    logic signed [W-1:0] fr_r [N];
    logic signed [W-1:0] fr_i [N];

    fft_reorder_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef FFT_REORDER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] brev(input logic [4:0] x);
        logic [4:0] y;
        for (int b = 0; b < 5; b++) y[b] = x[4-b];
        return y;
    endfunction

    // Pushes the natural-order expectation, then feeds samples in bit-reversed order.
    task automatic drive_frame(input bit gapped);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.idx  = 5'(k);
            e.r    = fr_r[k];
            e.i    = fr_i[k];
            e.last = (k == N - 1);
            sb_q.push_back(e);
        end
        for (int p = 0; p < N; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r     = fr_r[brev(5'(p))];
            in_i     = fr_i[brev(5'(p))];
            if (p == N - 1) first_q.push_back(cyc + 2);
            if (gapped && p != N - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic collect(input int n, input int budget);
        int   got = 0;
        int   waited = 0;
        int   prev = 0;
        int   fe;
        exp_t e;
        while (got < n && waited < budget) begin
            @(negedge clk);
            waited++;
            if (out_valid) begin
                $display("[TB] out idx=%0d r=%0d i=%0d last=%0b @%0d", out_idx, out_r, out_i, out_last, cyc);
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got idx=%0d r=%0d i=%0d, required no output", out_idx, out_r, out_i);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_idx, out_r, out_i, out_last} !== {e.idx, e.r, e.i, e.last}) begin
                        n_fail++;
                        $display("FAIL sb_data: got idx=%0d r=%0d i=%0d last=%0b, required idx=%0d r=%0d i=%0d last=%0b",
                                 out_idx, out_r, out_i, out_last, e.idx, e.r, e.i, e.last);
                    end
                end
                if (out_idx == 5'd0 && first_q.size() > 0) begin
                    fe = first_q.pop_front();
                    n_tests++;
                    if (cyc !== fe) begin
                        n_fail++;
                        $display("FAIL latency: X[0] at edge %0d, required edge %0d", cyc, fe);
                    end
                end
                if (got > 0) begin
                    n_tests++;
                    if (cyc !== prev + 1) begin
                        n_fail++;
                        $display("FAIL gap: output at edge %0d, required edge %0d", cyc, prev + 1);
                    end
                end
                prev = cyc;
                got++;
            end
        end
        if (got < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d outputs, required %0d", got, n);
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b last=%0b, required 0 0", name, out_valid, out_last);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, out_last, out_idx, out_r, out_i} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b last=%0b idx=%0d r=%0d i=%0d, required all 0",
                     out_valid, out_last, out_idx, out_r, out_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released @%0d", cyc);
    endtask

    task automatic test_single_frame();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(k);
            fr_i[k] = W'(-k);
        end
        fork
            begin drive_frame(1'b0); @(negedge clk); in_valid = 1'b0; end
            collect(32, 200);
        join
        @(negedge clk);
        check_idle("single_end");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int k = 0; k < N; k++) begin
                    fr_r[k] = W'(k);
                    fr_i[k] = W'(-k);
                end
                drive_frame(1'b0);
                for (int k = 0; k < N; k++) begin
                    fr_r[k] = W'(k + 100);
                    fr_i[k] = W'(-(k + 100));
                end
                drive_frame(1'b0);
                @(negedge clk);
                in_valid = 1'b0;
            end
            collect(64, 300);
        join
        @(negedge clk);
        check_idle("b2b_end");
    endtask

    task automatic test_gapped();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(3 * k - 50);
            fr_i[k] = W'(k * k);
        end
        fork
            begin drive_frame(1'b1); @(negedge clk); in_valid = 1'b0; end
            collect(32, 300);
        join
        @(negedge clk);
        check_idle("gapped_end");
    endtask

    task automatic test_extremes();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(-262144);
            fr_i[k] = W'(262143);
        end
        fork
            begin drive_frame(1'b0); @(negedge clk); in_valid = 1'b0; end
            collect(32, 200);
        join
        @(negedge clk);
        check_idle("extremes_end");
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 17; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r     = W'(1000 + p);
            in_i     = W'(-1000 - p);
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_last, out_idx, out_r, out_i} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got valid=%0b last=%0b idx=%0d r=%0d i=%0d, required all 0",
                     out_valid, out_last, out_idx, out_r, out_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(50 - k);
            fr_i[k] = W'(3 * k);
        end
        fork
            begin drive_frame(1'b0); @(negedge clk); in_valid = 1'b0; end
            collect(32, 200);
        join
        @(negedge clk);
        check_idle("reset_mid_end");
    endtask

`ifdef FFT_REORDER_FLUSH_EN
    task automatic test_flush();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(k + 7);
            fr_i[k] = W'(-2 * k);
        end
        fork
            begin drive_frame(1'b0); @(negedge clk); in_valid = 1'b0; end
            collect(11, 200);
        join
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush_next_edge");
        sb_q.delete();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = W'(200 - k);
            fr_i[k] = W'(k + 11);
        end
        fork
            begin drive_frame(1'b0); @(negedge clk); in_valid = 1'b0; end
            collect(32, 200);
        join
        @(negedge clk);
        check_idle("flush_frame_end");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_reset_mid();
`ifdef FFT_REORDER_FLUSH_EN
        test_flush();
`endif
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
